pc_ras: RTL
===========

# pc_ras

Parametrised program counter for the pipelined LEGv8 CPU fetch stage. It adds configurable width and step, a pipeline stall, and a prioritised branch redirect. A return-address stack (RAS) accelerates BL/RET. The block sits at the head of IF and drives the instruction-memory address; redirects come from the branch-resolution stage.

## Interface
Parameters:
- WIDTH, 64, counter and address width in bits
- STEP, 1, sequential increment (1 = word-addressed instruction memory)
- RESET_VALUE, 0, counter value after reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  hold counter (hazard unit)
- redirect_en  input  1  branch/jump taken; load redirect_target
- redirect_target  input  WIDTH  branch/jump destination
- call  input  1  qualifies redirect_en as BL; push return address
- ret  input  1  RET; pop RAS top into counter
- counter  output  WIDTH  current fetch address (registered)
- ras_empty  output  1  RAS holds no entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_overflow  output  1  sticky: push occurred while full
- ras_underflow  output  1  sticky: ret occurred while empty

## Operation
The next-state priority is evaluated each rising edge, highest first:
1. reset: counter=RESET_VALUE; RAS count=0, pointer=0; ras_overflow=ras_underflow=0.
2. redirect_en: counter=redirect_target. If call=1, also push (counter+STEP) mod 2^WIDTH. Any ret in the same cycle is ignored.
3. ret with RAS non-empty: counter=top entry; pop (count−1).
4. ret with RAS empty: counter holds; ras_underflow set.
5. stall: counter holds.
6. otherwise: counter=(counter+STEP) mod 2^WIDTH.

Additional rules:
- redirect and ret both override stall; the hazard unit guarantees that is legal.
- call without redirect_en is ignored: no push, no counter effect.
- The RAS is circular with write pointer wp and count. Push writes entry[wp] and sets wp=wp+1 mod RAS_DEPTH. Count saturates at RAS_DEPTH.
- Push while full overwrites the oldest entry and sets ras_overflow. Count stays at RAS_DEPTH.
- Pop reads entry[wp−1] and sets wp=wp−1 mod RAS_DEPTH.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are derived from registered count.
- Sticky flags clear only on reset.
- Arithmetic is unsigned. The WIDTH-bit sum drops its carry, so the counter wraps from 2^WIDTH−STEP to 0.

## Timing
- Latency: one cycle. Inputs sampled at edge N are reflected on counter after edge N.
- counter, flags and RAS state are all registered. There is no combinational path from any input to any output.
- Reset value: counter=RESET_VALUE, ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
- Reset mid-operation: reset asserted concurrently with redirect, call, ret or stall wins. The in-flight push or pop is discarded.
- Back-to-back call then ret: the pushed entry is visible to the ret issued on the very next cycle.
- Back-to-back pushes and pops are permitted every cycle.

## Configuration
- PC_RAS_EN defined: RAS storage and logic are present as described above.
- PC_RAS_EN undefined: no RAS storage.
  - call and ret are ignored; ret behaves as if not asserted, so it falls through to stall or increment.
  - ras_empty=1; ras_full, ras_overflow and ras_underflow are tied 0.
  - Port list is unchanged.

## Test plan
- Reset, then 5 free-running cycles, STEP=1 → counter 0,1,2,3,4,5; ras_empty=1.
- counter=8, stall=1 for 3 cycles, then redirect_en=1 with redirect_target=0x40 and stall=1 → counter holds at 8 for 3 cycles, then 0x40, then 0x41.
- counter=0x10, redirect_en=1, call=1, redirect_target=0x100 → counter=0x100, RAS top=0x11. Two cycles later, ret=1 → counter=0x11, ras_empty=1.
- RAS_DEPTH=4: five calls with return addresses A1..A5 → ras_full=1, ras_overflow=1. Four rets → A5,A4,A3,A2. A fifth ret → counter holds, ras_underflow=1.
- WIDTH=8, STEP=4, counter=0xFC, free-run → 0x00; redirect_en and ret asserted together → counter=redirect_target and RAS unchanged.
- Reset asserted in the same cycle as a call/redirect → counter=RESET_VALUE, ras_empty=1, flags 0. Build without PC_RAS_EN, call+ret sequence → no return-address stack effect, ras_full=0.

Source files
------------

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with stall, prioritised redirect and an
// optional circular return-address stack for BL/RET acceleration.
// Build option: define PC_RAS_EN to include the return-address stack; without
// it call/ret are ignored and the RAS flags read as empty/not-full/clear.
module pc_ras #(
    parameter int unsigned       WIDTH       = 64,
    parameter int unsigned       STEP        = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] counter,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] counter_q, counter_d;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Next-state priority: redirect (with optional push) > ret > stall > increment.
    always_comb begin
        counter_d = counter_q;
        ras_d     = ras_q;
        wp_d      = wp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (redirect_en) begin
            counter_d = redirect_target;
            if (call) begin
                // Write pointer wraps naturally; a push while full overwrites the oldest slot.
                ras_d[wp_q] = counter_q + STEP_W;
                wp_d        = wp_q + PTR_W'(1);
                if (cnt_q == DEPTH_C) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (ret && (cnt_q != '0)) begin
            counter_d = ras_q[wp_q - PTR_W'(1)];
            wp_d      = wp_q - PTR_W'(1);
            cnt_d     = cnt_q - CNT_W'(1);
        end else if (ret) begin
            unf_d = 1'b1;
        end else if (!stall) begin
            counter_d = counter_q + STEP_W;
        end
    end

    // Counter, stack pointer, occupancy and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= RESET_VALUE;
            wp_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Stack storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ras_q <= ras_d;
        end
    end

    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == DEPTH_C);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{call, ret};

    // Next-state priority without a stack: redirect > stall > increment.
    always_comb begin
        counter_d = counter_q + STEP_W;
        if (redirect_en) begin
            counter_d = redirect_target;
        end else if (stall) begin
            counter_d = counter_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= RESET_VALUE;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    assign counter = counter_q;

endmodule
